// File: rtl/adder_pkg.sv
// rtl/adder_pkg.sv - shared constants and per-stage pipeline record for pipelined_adder
package adder_pkg;

  localparam int DEFAULT_WIDTH  = 32;
  localparam int DEFAULT_STAGES = 4;

  // Bit positions of the flags inside the write-back flag register
  localparam int FLAG_C    = 0;
  localparam int FLAG_V    = 1;
  localparam int FLAG_Z    = 2;
  localparam int FLAG_N    = 3;
  localparam int NUM_FLAGS = 4;

  // Control part of one pipeline stage; operand slices and partial sums sit
  // alongside it in width-parameterised arrays inside the top.
  typedef struct packed {
    logic valid;
    logic carry;
    logic sign_a;
    logic sign_b;
  } stage_ctrl_t;

endpackage

// File: rtl/adder_segment.sv
// rtl/adder_segment.sv - combinational SEG-bit slice adder with carry and sign out
module adder_segment
  import adder_pkg::*;
#(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           carry_i,
  output logic [SEG-1:0] sum_o,
  output logic           carry_o,
  output logic           sign_o
);

  assign {carry_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{SEG{1'b0}}, carry_i};
  assign sign_o = sum_o[SEG-1];

endmodule

// File: rtl/pipelined_adder.sv
// rtl/pipelined_adder.sv - segmented add/subtract pipeline; PIPELINED_ADDER_SAT_EN enables signed saturation
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int STAGES = DEFAULT_STAGES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             subtract,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             flag_c,
  output logic             flag_v,
  output logic             flag_z,
  output logic             flag_n
);

  localparam int SEG = WIDTH / STAGES;
  localparam int TOP = (STAGES - 1) * SEG;

  // Rank k holds an operation whose segments 0..k-1 are already summed;
  // segment k is added combinationally between rank k and rank k+1.
  stage_ctrl_t      ctl_q [STAGES];
  stage_ctrl_t      ctl_d [STAGES];
  logic [WIDTH-1:0] opa_q [STAGES];
  logic [WIDTH-1:0] opa_d [STAGES];
  logic [WIDTH-1:0] opb_q [STAGES];
  logic [WIDTH-1:0] opb_d [STAGES];
  logic [WIDTH-1:0] sum_q [STAGES];
  logic [WIDTH-1:0] sum_d [STAGES];

  logic [SEG-1:0]   seg_sum   [STAGES];
  logic             seg_carry [STAGES];
  logic             seg_sign  [STAGES];

  logic             advance;
  logic             accept;
  logic [WIDTH-1:0] b_prime;
  stage_ctrl_t      last_ctl;
  logic [WIDTH-1:0] raw_sum;
  logic             overflow;
  logic [WIDTH-1:0] result_d;
  logic [WIDTH-1:0] result_q;
  logic [NUM_FLAGS-1:0] flags_d;
  logic [NUM_FLAGS-1:0] flags_q;
  logic             out_valid_q;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance && !reset;
  assign accept   = in_valid && in_ready;
  assign b_prime  = subtract ? ~b : b;

  for (genvar k = 0; k < STAGES; k++) begin : g_seg
    adder_segment #(.SEG(SEG)) u_segment (
      .a_i    (opa_q[k][k*SEG +: SEG]),
      .b_i    (opb_q[k][k*SEG +: SEG]),
      .carry_i(ctl_q[k].carry),
      .sum_o  (seg_sum[k]),
      .carry_o(seg_carry[k]),
      .sign_o (seg_sign[k])
    );
  end

  // Next contents of every rank: new operands enter rank 0, older ranks take the segment result below them
  always_comb begin
    ctl_d[0] = '{valid: accept, carry: subtract, sign_a: a[WIDTH-1], sign_b: b_prime[WIDTH-1]};
    opa_d[0] = a;
    opb_d[0] = b_prime;
    sum_d[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      ctl_d[k]       = ctl_q[k-1];
      ctl_d[k].carry = seg_carry[k-1];
      opa_d[k]       = opa_q[k-1];
      opb_d[k]       = opb_q[k-1];
      sum_d[k]       = sum_q[k-1];
      sum_d[k][(k-1)*SEG +: SEG] = seg_sum[k-1];
    end
  end

  // Pipeline ranks shift together on advance and all hold during a stall
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        ctl_q[k] <= '0;
        opa_q[k] <= '0;
        opb_q[k] <= '0;
        sum_q[k] <= '0;
      end
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        ctl_q[k] <= ctl_d[k];
        opa_q[k] <= opa_d[k];
        opb_q[k] <= opb_d[k];
        sum_q[k] <= sum_d[k];
      end
    end
  end

  assign last_ctl = ctl_q[STAGES-1];

  // Full raw sum: lower segments from the last rank, top segment straight from its adder
  always_comb begin
    raw_sum = sum_q[STAGES-1];
    raw_sum[TOP +: SEG] = seg_sum[STAGES-1];
  end

  assign overflow = (last_ctl.sign_a == last_ctl.sign_b) &&
                    (seg_sign[STAGES-1] != last_ctl.sign_a);

`ifdef PIPELINED_ADDER_SAT_EN
  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  // Overflowing results clamp toward the sign both operands share
  assign result_d = overflow ? (last_ctl.sign_a ? SAT_MIN : SAT_MAX) : raw_sum;
`else
  assign result_d = raw_sum;
`endif

  // Flags; zero and negative describe the value actually emitted
  always_comb begin
    flags_d         = '0;
    flags_d[FLAG_C] = seg_carry[STAGES-1];
    flags_d[FLAG_V] = overflow;
    flags_d[FLAG_Z] = (result_d == '0);
    flags_d[FLAG_N] = result_d[WIDTH-1];
  end

  // Output register: bubbles clear out_valid but leave result and flags untouched
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      flags_q     <= '0;
    end else if (advance) begin
      out_valid_q <= last_ctl.valid;
      if (last_ctl.valid) begin
        result_q <= result_d;
        flags_q  <= flags_d;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign flag_c    = flags_q[FLAG_C];
  assign flag_v    = flags_q[FLAG_V];
  assign flag_z    = flags_q[FLAG_Z];
  assign flag_n    = flags_q[FLAG_N];

endmodule
